tx_packet_generator: RTL

Synchronous packet source that sits directly upstream of `ft245_transmitter` on the `slow_clock` domain. It produces a continuous stream of framed 32-bit test packets (header, counting payload, optional checksum trailer) over a valid/ready handshake. The transmitter's write path consumes the stream and pushes it to the FT601 over USB.

---
 rtl/ft_pkg.sv | 13 +
 rtl/tx_packet_generator.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared state encoding and constants for the ft245 transmit path
package ft_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] TRAILER = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hA55A;
  localparam logic [3:0]  BE_ALL        = 4'hF;

endpackage

// File: rtl/tx_packet_generator.sv
// rtl/tx_packet_generator.sv - framed counting-packet source; checksum trailer under TX_GEN_CHECKSUM_EN
module tx_packet_generator
  import ft_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 256,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter logic [15:0] MAGIC         = DEFAULT_MAGIC
) (
  input  logic        slow_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic [3:0]  o_be,
  output logic        o_last,
  output logic        o_busy,
  output logic [15:0] o_seq
);

  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_WORDS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  logic [2:0]  r_state, w_state_nxt, w_pkt_exit;
  logic [15:0] r_idx, w_idx_nxt;
  logic [15:0] r_gap, w_gap_nxt;
  logic [15:0] r_seq, w_seq_nxt;
  logic [31:0] r_pcnt, w_pcnt_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_last, w_last_nxt;
  logic        r_busy, w_busy_nxt;
  logic        w_xfer, w_last_pay;
`ifdef TX_GEN_CHECKSUM_EN
  logic [31:0] r_csum, w_csum_nxt;
`endif

  assign w_xfer     = r_valid && i_ready;
  assign w_last_pay = (r_idx == LAST_IDX);
  // i_enable only matters where a packet boundary is crossed
  assign w_pkt_exit = (GAP_CYCLES != 0) ? GAP : (i_enable ? HEADER : IDLE);

  always_ff @(posedge slow_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_enable) w_state_nxt = HEADER;
      HEADER:  if (w_xfer) w_state_nxt = PAYLOAD;
`ifdef TX_GEN_CHECKSUM_EN
      PAYLOAD: if (w_xfer && w_last_pay) w_state_nxt = TRAILER;
      TRAILER: if (w_xfer) w_state_nxt = w_pkt_exit;
`else
      PAYLOAD: if (w_xfer && w_last_pay) w_state_nxt = w_pkt_exit;
`endif
      GAP:     if (r_gap == GAP_LAST) w_state_nxt = i_enable ? HEADER : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_idx_nxt  = r_idx;
    w_gap_nxt  = r_gap;
    w_seq_nxt  = r_seq;
    w_pcnt_nxt = r_pcnt;
`ifdef TX_GEN_CHECKSUM_EN
    w_csum_nxt = r_csum;
`endif
    if (r_state == HEADER && w_xfer) begin
      w_idx_nxt = '0;
`ifdef TX_GEN_CHECKSUM_EN
      w_csum_nxt = {MAGIC, r_seq};
`endif
    end
    if (r_state == PAYLOAD && w_xfer) begin
      w_idx_nxt  = r_idx + 16'd1;
      w_pcnt_nxt = r_pcnt + 32'd1;
`ifdef TX_GEN_CHECKSUM_EN
      w_csum_nxt = r_csum + r_pcnt;
`else
      if (w_last_pay) w_seq_nxt = r_seq + 16'd1;
`endif
    end
`ifdef TX_GEN_CHECKSUM_EN
    if (r_state == TRAILER && w_xfer) w_seq_nxt = r_seq + 16'd1;
`endif
    if (w_state_nxt == GAP) w_gap_nxt = (r_state == GAP) ? r_gap + 16'd1 : 16'd0;
  end

  // outputs are decoded from the next state so they register in step with it
  always_comb begin
    w_valid_nxt = (w_state_nxt == HEADER) || (w_state_nxt == PAYLOAD) ||
                  (w_state_nxt == TRAILER);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_data_nxt  = r_data;
    case (w_state_nxt)
      HEADER:  w_data_nxt = {MAGIC, w_seq_nxt};
      PAYLOAD: w_data_nxt = w_pcnt_nxt;
`ifdef TX_GEN_CHECKSUM_EN
      TRAILER: w_data_nxt = w_csum_nxt;
`endif
      default: w_data_nxt = r_data;
    endcase
`ifdef TX_GEN_CHECKSUM_EN
    w_last_nxt = (w_state_nxt == TRAILER);
`else
    w_last_nxt = (w_state_nxt == PAYLOAD) && (w_idx_nxt == LAST_IDX);
`endif
  end

  always_ff @(posedge slow_clock) begin
    if (i_reset) begin
      r_idx   <= '0;
      r_gap   <= '0;
      r_seq   <= '0;
      r_pcnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef TX_GEN_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_seq   <= w_seq_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
`ifdef TX_GEN_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_be    = BE_ALL;
  assign o_last  = r_last;
  assign o_busy  = r_busy;
  assign o_seq   = r_seq;

endmodule
